// File: rtl/md5_job_dispatcher.sv
// md5_job_dispatcher
//   Avalon-MM slave that queues {start,count} MD5 search jobs from the HPS,
//   hands them round-robin to idle cores, counts completions and latches the
//   first reported match.
// Ports:
//   clk, reset                  clock, async active-high reset
//   avs_address/read/write/     word-addressed register port; readdata is
//   writedata/readdata          registered one cycle after avs_read
//   job_valid/ready/start/count per-core job offer (valid held until ready)
//   done_valid/found/word       per-core completion pulse and match result
//   irq                         irq_en & found
//   seg_value                   JOBS_DONE[23:0]

// One per core: job registers, offer valid and busy flag.
module md5_dispatch_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_start,
  input  logic [31:0] load_count,
  input  logic        drop,
  input  logic        ready,
  input  logic        done,
  output logic        valid,
  output logic        busy,
  output logic [31:0] start,
  output logic [31:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      busy  <= 1'b0;
      start <= '0;
      count <= '0;
    end else begin
      if (load) begin
        start <= load_start;
        count <= load_count;
      end
      if (drop)               valid <= 1'b0;
      else if (load)          valid <= 1'b1;
      else if (valid && ready) valid <= 1'b0;
      // A handshake on the wire means the core took the job, even if the
      // offer is being dropped by a soft clear in the same cycle.
      busy <= (busy & ~done) | (valid & ready);
    end
  end
endmodule

module md5_job_dispatcher #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             avs_address,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  output logic [31:0]            avs_readdata,
  output logic [NUM_CORES-1:0]    job_valid,
  input  logic [NUM_CORES-1:0]    job_ready,
  output logic [32*NUM_CORES-1:0] job_start,
  output logic [32*NUM_CORES-1:0] job_count,
  input  logic [NUM_CORES-1:0]    done_valid,
  input  logic [NUM_CORES-1:0]    done_found,
  input  logic [32*NUM_CORES-1:0] done_word,
  output logic                   irq,
  output logic [23:0]            seg_value
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic           enable, irq_en, found, overflow;
  logic [31:0]    job_cnt, result, jobs_done;
  logic [CW-1:0]  result_core, rr_ptr;
  logic [63:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level;
  logic [NUM_CORES-1:0] busy, load_vec, hits;

  // register decode
  logic wr_ctrl, soft_clear, push, wr_cnt, clr_found, clr_ovf;
  assign wr_ctrl    = avs_write && (avs_address == 3'd0);
  assign soft_clear = wr_ctrl && avs_writedata[1];
  assign push       = avs_write && (avs_address == 3'd2);
  assign wr_cnt     = avs_write && (avs_address == 3'd3);
  assign clr_found  = avs_write && (avs_address == 3'd7) && avs_writedata[10];
  assign clr_ovf    = avs_write && (avs_address == 3'd7) && avs_writedata[11];

  logic empty, full;
  assign empty = (level == '0);
  assign full  = (level == LW'(FIFO_DEPTH));

  // round-robin search for an idle core starting at rr_ptr
  logic          grant_ok;
  logic [CW-1:0] grant_idx, idx;
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = CW'((int'(rr_ptr) + k) % NUM_CORES);
      if (!grant_ok && !busy[idx]) begin
        grant_ok  = 1'b1;
        grant_idx = idx;
      end
    end
  end

  logic dispatch, push_ok, ovf_set;
  logic [63:0] head;
  assign dispatch = enable && !empty && !(|job_valid) && grant_ok && !soft_clear;
  assign push_ok  = push && (!full || dispatch);
  assign ovf_set  = push && full && !dispatch;
  assign head     = fifo_mem[rd_ptr];
  assign load_vec = dispatch ? (NUM_CORES'(1) << grant_idx) : '0;

  // FIFO storage carries no reset; validity is tracked by level/pointers
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= {avs_writedata, (job_cnt == '0) ? 32'd1 : job_cnt};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rr_ptr <= '0;
    end else begin
      if (soft_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
        if (dispatch) rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !dispatch)      level <= level + 1'b1;
        else if (!push_ok && dispatch) level <= level - 1'b1;
      end
      if (dispatch)
        rr_ptr <= (grant_idx == CW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_slot
      md5_dispatch_slot u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (load_vec[gi]),
        .load_start (head[63:32]),
        .load_count (head[31:0]),
        .drop       (soft_clear),
        .ready      (job_ready[gi]),
        .done       (done_valid[gi]),
        .valid      (job_valid[gi]),
        .busy       (busy[gi]),
        .start      (job_start[32*gi +: 32]),
        .count      (job_count[32*gi +: 32])
      );
    end
  endgenerate

  // completion: lowest-index busy core reporting a match wins
  logic          hit_any, capture;
  logic [CW-1:0] hit_idx;
  logic [3:0]    done_cnt;
  logic [32:0]   done_sum;
  assign hits = done_valid & done_found & busy;
  always_comb begin
    hit_idx  = '0;
    done_cnt = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (hits[k]) hit_idx = CW'(k);
    for (int k = 0; k < NUM_CORES; k++)
      done_cnt = done_cnt + 4'(done_valid[k]);
  end
  assign hit_any  = |hits;
  // a match arriving with a found-clear in the same cycle re-arms found
  assign capture  = hit_any && (!found || clr_found);
  assign done_sum = {1'b0, jobs_done} + 33'(done_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      job_cnt     <= '0;
      found       <= 1'b0;
      overflow    <= 1'b0;
      result      <= '0;
      result_core <= '0;
      jobs_done   <= '0;
    end else begin
      if (wr_ctrl) begin
        enable <= avs_writedata[0];
        irq_en <= avs_writedata[2];
      end
      if (wr_cnt) job_cnt <= avs_writedata;
      if (soft_clear) begin
        found       <= 1'b0;
        overflow    <= 1'b0;
        result      <= '0;
        result_core <= '0;
        jobs_done   <= '0;
      end else begin
        if (capture) begin
          found       <= 1'b1;
          result      <= done_word[32*hit_idx +: 32];
          result_core <= hit_idx;
        end else if (clr_found) begin
          found <= 1'b0;
        end
        if (ovf_set)      overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
        jobs_done <= done_sum[32] ? 32'hFFFF_FFFF : done_sum[31:0];
      end
    end
  end

  // register read mux
  logic [31:0] status, rdata;
  assign status = {8'h00, 8'(busy), 4'h0, overflow, found, empty, full, 1'b0, 7'(level)};
  always_comb begin
    rdata = '0;
    case (avs_address)
      3'd0: rdata = {29'd0, irq_en, 1'b0, enable};
      3'd1: rdata = status;
      3'd3: rdata = job_cnt;
      3'd4: rdata = result;
      3'd5: rdata = 32'(result_core);
      3'd6: rdata = jobs_done;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) avs_readdata <= '0;
    else       avs_readdata <= avs_read ? rdata : '0;
  end

  assign irq       = irq_en & found;
  assign seg_value = jobs_done[23:0];
endmodule

// File: tb/tb_md5_job_dispatcher.sv
// Testbench for md5_job_dispatcher (NUM_CORES=4, FIFO_DEPTH=8).
// Reads and job handshakes are checked by a monitor against queues of
// expected values filled when the stimulus is issued.
module tb_md5_job_dispatcher;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   avs_address;
  logic         avs_read, avs_write;
  logic [31:0]  avs_writedata, avs_readdata;
  logic [N-1:0] job_valid, job_ready, done_valid, done_found;
  logic [32*N-1:0] job_start, job_count, done_word;
  logic         irq;
  logic [23:0]  seg_value;

  md5_job_dispatcher #(.NUM_CORES(N), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_start(job_start), .job_count(job_count),
    .done_valid(done_valid), .done_found(done_found), .done_word(done_word),
    .irq(irq), .seg_value(seg_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_nm_q[$];
  int          of_core_q[$];
  logic [31:0] of_start_q[$];
  logic [31:0] of_count_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // monitor
  logic rd_d;
  always @(posedge clk) rd_d <= avs_read;

  always @(negedge clk) begin
    logic [N-1:0] hs;
    int c;
    if (reset === 1'b0) begin
      if (rd_d === 1'b1) begin
        if (rd_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read got 0x%08h want none", avs_readdata);
        end else
          chk(rd_nm_q.pop_front(), avs_readdata, rd_exp_q.pop_front());
      end
      hs = job_valid & job_ready;
      if (hs != '0) begin
        c = 0;
        for (int k = 0; k < N; k++) if (hs[k]) c = k;
        if (of_core_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_offer got core %0d start 0x%08h want none", c, job_start[32*c +: 32]);
        end else begin
          chk("offer_core",  32'(c), 32'(of_core_q.pop_front()));
          chk("offer_start", job_start[32*c +: 32], of_start_q.pop_front());
          chk("offer_count", job_count[32*c +: 32], of_count_q.pop_front());
        end
      end
    end
  end

  // stimulus helpers: each starts and ends 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    step(1);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    rd_exp_q.push_back(exp); rd_nm_q.push_back(nm);
    avs_address = a; avs_read = 1'b1;
    step(1);
    avs_read = 1'b0;
    step(1);
  endtask

  task automatic expect_offer(input int c, input logic [31:0] s, input logic [31:0] n);
    of_core_q.push_back(c); of_start_q.push_back(s); of_count_q.push_back(n);
  endtask

  task automatic done_pulse(input logic [N-1:0] v, input logic [N-1:0] f, input logic [32*N-1:0] w);
    done_valid = v; done_found = f; done_word = w;
    step(1);
    done_valid = '0; done_found = '0;
  endtask

  initial begin
    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    job_ready = '0; done_valid = '0; done_found = '0; done_word = '0;
    #12;
    chk("rst_job_valid", 32'(job_valid), 32'h0);
    chk("rst_irq",       32'(irq),       32'h0);
    chk("rst_readdata",  avs_readdata,   32'h0);
    chk("rst_seg",       32'(seg_value), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1);
    rd(3'd1, 32'h0000_0200, "status_reset");

    // two jobs dispatched round-robin from core 0
    job_ready = '1;
    wr(3'd3, 32'd100);
    expect_offer(0, 32'h10, 32'd100);
    expect_offer(1, 32'h20, 32'd100);
    wr(3'd2, 32'h10);
    wr(3'd2, 32'h20);
    wr(3'd0, 32'h1);
    step(8);
    rd(3'd1, 32'h0003_0200, "status_two_busy");

    // third job lands on core 2, then cores 2 and 1 report matches together
    expect_offer(2, 32'h30, 32'd100);
    wr(3'd2, 32'h30);
    step(5);
    wr(3'd0, 32'h5);
    done_pulse(4'b0110, 4'b0110, {32'h0, 32'hAA, 32'hBB, 32'h0});
    rd(3'd4, 32'hBB,        "result");
    rd(3'd5, 32'd1,         "result_core");
    rd(3'd6, 32'd2,         "jobs_done_2");
    chk("irq_found", 32'(irq), 32'h1);
    chk("seg_2", 32'(seg_value), 32'd2);
    rd(3'd1, 32'h0001_0600, "status_found");

    // found clear coinciding with a new match: the set wins
    avs_address = 3'd7; avs_writedata = 32'h400; avs_write = 1'b1;
    done_pulse(4'b0001, 4'b0001, {96'h0, 32'hCC});
    avs_write = 1'b0;
    chk("irq_set_wins", 32'(irq), 32'h1);
    rd(3'd6, 32'd3, "jobs_done_3");
    wr(3'd7, 32'h400);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd(3'd1, 32'h0000_0200, "status_cleared");

    // overflow: 9 pushes while disabled, 9th is dropped
    wr(3'd0, 32'h0);
    for (int i = 0; i < 9; i++) wr(3'd2, 32'h100 + 32'(i));
    rd(3'd1, 32'h0000_0908, "status_full_ovf");
    expect_offer(3, 32'h100, 32'd100);
    expect_offer(0, 32'h101, 32'd100);
    expect_offer(1, 32'h102, 32'd100);
    expect_offer(2, 32'h103, 32'd100);
    expect_offer(3, 32'h104, 32'd100);
    expect_offer(0, 32'h105, 32'd100);
    expect_offer(1, 32'h106, 32'd100);
    expect_offer(2, 32'h107, 32'd100);
    wr(3'd0, 32'h1);
    step(12);
    done_pulse(4'b1111, 4'b0000, '0);
    step(12);
    done_pulse(4'b1111, 4'b0000, '0);
    step(6);
    rd(3'd1, 32'h0000_0A00, "status_drained");
    rd(3'd6, 32'd11, "jobs_done_11");

    // count of 0 is pushed as 1
    wr(3'd3, 32'd0);
    rd(3'd3, 32'd0, "job_count_reg");
    expect_offer(3, 32'h500, 32'd1);
    wr(3'd2, 32'h500);
    step(5);

    // pending offer, then soft clear
    job_ready = '0;
    wr(3'd2, 32'h600);
    wr(3'd2, 32'h700);
    step(3);
    chk("pending_valid", 32'(job_valid), 32'h1);
    chk("pending_start", job_start[31:0], 32'h600);
    chk("pending_count", job_count[31:0], 32'd1);
    rd(3'd1, 32'h0008_0801, "status_pending");
    wr(3'd0, 32'h3);
    chk("softclr_valid", 32'(job_valid), 32'h0);
    rd(3'd1, 32'h0008_0200, "status_softclr");
    rd(3'd0, 32'h1, "ctrl_readback");
    rd(3'd6, 32'd0, "jobs_done_softclr");
    job_ready = '1;
    step(6);
    chk("seg_softclr", 32'(seg_value), 32'h0);
    rd(3'd2, 32'h0, "wo_reads_zero");

    step(2);
    chk("read_q_empty",  32'(rd_exp_q.size()),  32'h0);
    chk("offer_q_empty", 32'(of_core_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
